// File: rtl/count_sched_pkg.sv
// Shared types and defaults for count_scheduler (optional abort: COUNT_SCHED_ABORT_EN).
package count_sched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StRun   = 2'd2,
    StDone  = 2'd3
  } sched_state_e;

  localparam int unsigned NREQ_DEFAULT  = 4;
  localparam int unsigned LEN_W_DEFAULT = 4;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/count_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after pointer, wrapping modulo NREQ.
module rr_arbiter
  import count_sched_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEFAULT,
  parameter int unsigned PTR_W = ptr_width(NREQ_DEFAULT)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] pointer,
  output logic [NREQ-1:0]  winner,
  output logic [PTR_W-1:0] winner_idx,
  output logic             valid
);

  always_comb begin
    int unsigned j;
    logic [PTR_W-1:0] jj;
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    j          = 0;
    jj         = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      j = 32'(pointer) + 32'(k);
      if (j >= NREQ) j = j - NREQ;
      jj = PTR_W'(j);
      if (!valid && req[jj]) begin
        valid      = 1'b1;
        winner[jj] = 1'b1;
        winner_idx = jj;
      end
    end
  end

endmodule

// File: rtl/count_scheduler.sv
// Round-robin owner of a shared counter: clear, enable for len cycles, done pulse.
// Optional abort input/aborted output when COUNT_SCHED_ABORT_EN is defined.
module count_scheduler
  import count_sched_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEFAULT,
  parameter int unsigned LEN_W = LEN_W_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] len,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  cnt_clear,
  output logic                  cnt_enable,
  output logic [NREQ-1:0]       done
`ifdef COUNT_SCHED_ABORT_EN
  ,
  input  logic                  abort,
  output logic                  aborted
`endif
);

  localparam int unsigned PTR_W = ptr_width(NREQ);

  sched_state_e     state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             clear_q, clear_d;
  logic             enable_q, enable_d;
  logic             aborted_q, aborted_d;

  logic [NREQ-1:0]  win_onehot;
  logic [PTR_W-1:0] win_idx;
  logic             win_valid;
  logic [LEN_W-1:0] sel_len;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req        (req),
    .pointer    (ptr_q),
    .winner     (win_onehot),
    .winner_idx (win_idx),
    .valid      (win_valid)
  );

  always_comb begin
    sel_len = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (win_onehot[i]) sel_len = len[i*LEN_W +: LEN_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    clear_d   = 1'b0;
    enable_d  = 1'b0;
    done_d    = '0;
    aborted_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          grant_d = win_onehot;
          rem_d   = sel_len;
          ptr_d   = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          clear_d = 1'b1;
          state_d = StClear;
        end
      end
      StClear: begin
        if (rem_q == '0) begin
          done_d  = grant_q;
          state_d = StDone;
        end else begin
          enable_d = 1'b1;
          state_d  = StRun;
        end
      end
      StRun: begin
        rem_d = rem_q - 1'b1;
`ifdef COUNT_SCHED_ABORT_EN
        if (abort) begin
          done_d    = grant_q;
          aborted_d = 1'b1;
          state_d   = StDone;
        end else
`endif
        if (rem_q == LEN_W'(1)) begin
          done_d  = grant_q;
          state_d = StDone;
        end else begin
          enable_d = 1'b1;
        end
      end
      StDone: begin
        grant_d = '0;
        state_d = StIdle;
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
    busy_d = |grant_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      done_q    <= '0;
      ptr_q     <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      clear_q   <= 1'b0;
      enable_q  <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      clear_q   <= clear_d;
      enable_q  <= enable_d;
      aborted_q <= aborted_d;
    end
  end

  assign grant      = grant_q;
  assign busy       = busy_q;
  assign cnt_clear  = clear_q;
  assign cnt_enable = enable_q;
  assign done       = done_q;
`ifdef COUNT_SCHED_ABORT_EN
  assign aborted    = aborted_q;
`endif

endmodule

// File: tb/tb_count_scheduler.sv
// Directed bench for count_scheduler; abort scenario built when COUNT_SCHED_ABORT_EN is defined.
module tb_count_scheduler;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] len;
  logic [3:0]  grant;
  logic        busy;
  logic        cnt_clear;
  logic        cnt_enable;
  logic [3:0]  done;
`ifdef COUNT_SCHED_ABORT_EN
  logic        abort;
  logic        aborted;
`endif

  int passed = 0;
  int total  = 0;

  count_scheduler #(
    .NREQ  (4),
    .LEN_W (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .len        (len),
    .grant      (grant),
    .busy       (busy),
    .cnt_clear  (cnt_clear),
    .cnt_enable (cnt_enable),
    .done       (done)
`ifdef COUNT_SCHED_ABORT_EN
    ,
    .abort      (abort),
    .aborted    (aborted)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observe and drive 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = '0;
    len   = '0;
`ifdef COUNT_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    tick();
    total++;
    if ({grant, busy, cnt_clear, cnt_enable, done} !== 11'b0) begin
      $display("FAIL reset_outputs: got %b want %b", {grant, busy, cnt_clear, cnt_enable, done},
               11'b0);
    end else passed++;
`ifdef COUNT_SCHED_ABORT_EN
    total++;
    if (aborted !== 1'b0) $display("FAIL reset_aborted: got %b want 0", aborted);
    else passed++;
`endif
    reset = 1'b0;
    tick();
    total++;
    if (grant !== 4'b0000) $display("FAIL idle_grant: got %b want 0000", grant);
    else passed++;
  endtask

  task automatic test_single();
    req = 4'b0001;
    len = 16'h0003;
    tick();
    req = 4'b0000;
    total++;
    if ({grant, busy, cnt_clear, cnt_enable} !== 7'b0001_1_1_0) begin
      $display("FAIL single_t1: got %b want %b", {grant, busy, cnt_clear, cnt_enable},
               7'b0001_1_1_0);
    end else passed++;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if ({grant, cnt_clear, cnt_enable, done} !== 10'b0001_0_1_0000) begin
        $display("FAIL single_run%0d: got %b want %b", c, {grant, cnt_clear, cnt_enable, done},
                 10'b0001_0_1_0000);
      end else passed++;
    end
    tick();
    total++;
    if ({grant, cnt_enable, done} !== 9'b0001_0_0001) begin
      $display("FAIL single_done: got %b want %b", {grant, cnt_enable, done}, 9'b0001_0_0001);
    end else passed++;
    tick();
    total++;
    if ({grant, busy, done} !== 9'b0000_0_0000) begin
      $display("FAIL single_release: got %b want %b", {grant, busy, done}, 9'b0);
    end else passed++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    req = 4'b1111;
    len = 16'h1111;
    for (int b = 0; b < 5; b++) begin
      exp = 4'(1 << (b % 4));
      tick();
      total++;
      if ({grant, cnt_clear} !== {exp, 1'b1}) begin
        $display("FAIL rr_grant%0d: got %b want %b", b, {grant, cnt_clear}, {exp, 1'b1});
      end else passed++;
      tick();
      total++;
      if (cnt_enable !== 1'b1) $display("FAIL rr_enable%0d: got %b want 1", b, cnt_enable);
      else passed++;
      tick();
      total++;
      if ({done, cnt_enable} !== {exp, 1'b0}) begin
        $display("FAIL rr_done%0d: got %b want %b", b, {done, cnt_enable}, {exp, 1'b0});
      end else passed++;
      if (b == 4) req = 4'b0000;
      tick();
      total++;
      if ({grant, busy} !== 5'b0) $display("FAIL rr_bubble%0d: got %b want 00000", b, {grant, busy});
      else passed++;
    end
  endtask

  task automatic test_zero_len();
    req = 4'b0100;
    len = 16'h0000;
    tick();
    req = 4'b0000;
    total++;
    if ({grant, cnt_clear, cnt_enable} !== 6'b0100_1_0) begin
      $display("FAIL zero_clear: got %b want %b", {grant, cnt_clear, cnt_enable}, 6'b0100_1_0);
    end else passed++;
    tick();
    total++;
    if ({grant, cnt_clear, cnt_enable, done} !== 10'b0100_0_0_0100) begin
      $display("FAIL zero_done: got %b want %b", {grant, cnt_clear, cnt_enable, done},
               10'b0100_0_0_0100);
    end else passed++;
    tick();
    total++;
    if ({grant, done} !== 8'b0) $display("FAIL zero_release: got %b want 00000000", {grant, done});
    else passed++;
  endtask

  task automatic test_deassert();
    int n;
    int at;
    req = 4'b0010;
    len = 16'h0050;
    tick();
    total++;
    if (grant !== 4'b0010) $display("FAIL deassert_grant: got %b want 0010", grant);
    else passed++;
    tick();
    req = 4'b0000;
    len = 16'h0000;
    n = (cnt_enable === 1'b1) ? 1 : 0;
    at = -1;
    for (int i = 1; i < 12; i++) begin
      tick();
      if (done !== 4'b0000) begin
        at = i;
        break;
      end
      if (cnt_enable === 1'b1) n++;
    end
    total++;
    if (n !== 5) $display("FAIL deassert_enables: got %0d want 5", n);
    else passed++;
    total++;
    if ({at, done} !== {32'd5, 4'b0010}) begin
      $display("FAIL deassert_done: got tick %0d done %b want tick 5 done 0010", at, done);
    end else passed++;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    req = 4'b0001;
    len = 16'h0004;
    tick();
    req = 4'b0000;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({grant, busy, cnt_enable, cnt_clear} !== 7'b0) begin
      $display("FAIL async_reset: got %b want 0000000", {grant, busy, cnt_enable, cnt_clear});
    end else passed++;
    @(posedge clock);
    #1;
    total++;
    if (done !== 4'b0000) $display("FAIL reset_no_done: got %b want 0000", done);
    else passed++;
    #2;
    reset = 1'b0;
    req = 4'b1001;
    len = 16'h0002;
    tick();
    total++;
    if (grant !== 4'b0001) $display("FAIL reset_pointer: got %b want 0001", grant);
    else passed++;
    req = 4'b0000;
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (grant !== 4'b0000) $display("FAIL reset_after_burst: got %b want 0000", grant);
    else passed++;
  endtask

`ifdef COUNT_SCHED_ABORT_EN
  task automatic test_abort();
    int n;
    req = 4'b0001;
    len = 16'h0008;
    tick();
    req = 4'b0000;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cnt_enable === 1'b1) n++;
    end
    abort = 1'b1;
    total++;
    if (n !== 3) $display("FAIL abort_enables: got %0d want 3", n);
    else passed++;
    tick();
    abort = 1'b0;
    total++;
    if ({done, aborted, cnt_enable} !== 6'b0001_1_0) begin
      $display("FAIL abort_done: got %b want %b", {done, aborted, cnt_enable}, 6'b0001_1_0);
    end else passed++;
    tick();
    total++;
    if ({grant, aborted} !== 5'b0) $display("FAIL abort_release: got %b want 00000", {grant, aborted});
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_len();
    test_deassert();
    test_reset_mid_burst();
`ifdef COUNT_SCHED_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
